// File: rtl/router_defs.sv
// Shared definitions for the 1x3 router control path: FSM state encodings,
// the reserved destination address and a per-port select helper.
package router_defs;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Picks the bit of a per-port vector addressed by a 2-bit destination;
    // the reserved address selects nothing.
    function automatic logic sel_port(input logic [2:0] vec, input logic [1:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            2'd0:    hit = vec[0];
            2'd1:    hit = vec[1];
            2'd2:    hit = vec[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Router control FSM: sequences header decode, payload load, full stall and
// parity handling, and drives Moore phase strobes, FIFO write enable and busy.
module router_ctrl_fsm
    import router_defs::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic [1:0]        addr_q
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] addr_d;
    logic [1:0] hdr_addr;
    logic       hdr_valid;
    logic [2:0] empty_vec;
    logic [2:0] soft_vec;
    logic       soft_hit;
    logic       unused_data;

    assign hdr_addr    = data_in[1:0];
    assign hdr_valid   = pkt_valid && (hdr_addr != ADDR_INVALID);
    assign empty_vec   = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec    = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign soft_hit    = sel_port(soft_vec, addr_q);
    assign unused_data = ^data_in[DATA_W-1:2];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    addr_d  = hdr_addr;
                    state_d = sel_port(empty_vec, hdr_addr) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_port(empty_vec, addr_q))
                    state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_d = DECODE_ADDRESS;
                else if (low_packet_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default: state_d = DECODE_ADDRESS;
        endcase
        // A timeout on the port we are feeding abandons the packet outright.
        if ((state_q != DECODE_ADDRESS) && soft_hit)
            state_d = DECODE_ADDRESS;
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = ld_state || laf_state || (state_q == LOAD_PARITY);
    assign busy          = !(detect_add || ld_state);

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: drives packet scenarios and compares the
// Moore output vector against hand-derived per-state patterns.
module tb_router_ctrl_fsm;

    // Output vector order: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] S_DECODE = 8'b1000_0000;
    localparam logic [7:0] S_LFD    = 8'b0100_0001;
    localparam logic [7:0] S_LD     = 8'b0010_0010;
    localparam logic [7:0] S_LAF    = 8'b0001_0011;
    localparam logic [7:0] S_FULL   = 8'b0000_1001;
    localparam logic [7:0] S_LP     = 8'b0000_0011;
    localparam logic [7:0] S_CHECK  = 8'b0000_0101;
    localparam logic [7:0] S_WAIT   = 8'b0000_0001;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy;
    logic [1:0] addr_q;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;

    router_ctrl_fsm #(.DATA_W(8)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done),
        .low_packet_valid(low_packet_valid), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q)
    );

    always #5 clock = ~clock;

    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        pkt_valid = 0; data_in = 8'h00; fifo_full = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_packet_valid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        #3;
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL reset_outs: got %b expected %b", outs, S_DECODE);
        end
        checks++;
        if (addr_q !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", addr_q);
        end
        step();
        resetn = 1;
        step(); step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL reset_idle: got %b expected %b", outs, S_DECODE);
        end
    endtask

    task automatic test_normal_packet();
        pkt_valid = 1; data_in = 8'h05; fifo_empty_1 = 1;
        step();
        checks++;
        if (outs !== S_LFD) begin
            errors++; $display("[TB] FAIL normal_lfd: got %b expected %b", outs, S_LFD);
        end
        checks++;
        if (addr_q !== 2'd1) begin
            errors++; $display("[TB] FAIL normal_addr: got %0d expected 1", addr_q);
        end
        for (int i = 0; i < 3; i++) begin
            data_in = 8'hA0 + 8'(i);
            step();
            checks++;
            if (outs !== S_LD) begin
                errors++; $display("[TB] FAIL normal_ld%0d: got %b expected %b", i, outs, S_LD);
            end
        end
        pkt_valid = 0; data_in = 8'h5C;
        step();
        checks++;
        if (outs !== S_LP) begin
            errors++; $display("[TB] FAIL normal_lp: got %b expected %b", outs, S_LP);
        end
        step();
        checks++;
        if (outs !== S_CHECK) begin
            errors++; $display("[TB] FAIL normal_check: got %b expected %b", outs, S_CHECK);
        end
        step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL normal_done: got %b expected %b", outs, S_DECODE);
        end
    endtask

    task automatic test_invalid_addr();
        pkt_valid = 1; data_in = 8'h03;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (outs !== S_DECODE || write_enb_reg !== 1'b0) begin
                errors++; $display("[TB] FAIL invalid_stay%0d: got %b expected %b", i, outs, S_DECODE);
            end
            checks++;
            if (addr_q !== 2'd1) begin
                errors++; $display("[TB] FAIL invalid_addr%0d: got %0d expected 1", i, addr_q);
            end
        end
        pkt_valid = 0;
    endtask

    task automatic test_busy_dest_full_stall();
        pkt_valid = 1; data_in = 8'h02; fifo_empty_2 = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            data_in = 8'h11;
            checks++;
            if (outs !== S_WAIT) begin
                errors++; $display("[TB] FAIL busy_wait%0d: got %b expected %b", i, outs, S_WAIT);
            end
        end
        checks++;
        if (addr_q !== 2'd2) begin
            errors++; $display("[TB] FAIL busy_addr: got %0d expected 2", addr_q);
        end
        fifo_empty_2 = 1;
        step();
        checks++;
        if (outs !== S_LFD) begin
            errors++; $display("[TB] FAIL busy_lfd: got %b expected %b", outs, S_LFD);
        end
        step();
        checks++;
        if (outs !== S_LD) begin
            errors++; $display("[TB] FAIL stall_ld: got %b expected %b", outs, S_LD);
        end
        fifo_full = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs !== S_FULL) begin
                errors++; $display("[TB] FAIL stall_full%0d: got %b expected %b", i, outs, S_FULL);
            end
        end
        fifo_full = 0; low_packet_valid = 1; pkt_valid = 0;
        step();
        checks++;
        if (outs !== S_LAF) begin
            errors++; $display("[TB] FAIL stall_laf: got %b expected %b", outs, S_LAF);
        end
        step();
        checks++;
        if (outs !== S_LP) begin
            errors++; $display("[TB] FAIL stall_lp: got %b expected %b", outs, S_LP);
        end
        low_packet_valid = 0;
        step();
        step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL stall_done: got %b expected %b", outs, S_DECODE);
        end
    endtask

    task automatic test_parity_done_priority();
        pkt_valid = 1; data_in = 8'h00; fifo_empty_0 = 1;
        step(); step();
        checks++;
        if (outs !== S_LD || addr_q !== 2'd0) begin
            errors++; $display("[TB] FAIL pd_ld: got %b/%0d expected %b/0", outs, addr_q, S_LD);
        end
        fifo_full = 1;
        step();
        fifo_full = 0;
        step();
        checks++;
        if (outs !== S_LAF) begin
            errors++; $display("[TB] FAIL pd_laf: got %b expected %b", outs, S_LAF);
        end
        parity_done = 1; low_packet_valid = 1;
        step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL pd_decode: got %b expected %b", outs, S_DECODE);
        end
        parity_done = 0; low_packet_valid = 0; pkt_valid = 0;
        step();
    endtask

    task automatic test_check_full();
        pkt_valid = 1; data_in = 8'h00;
        step(); step();
        pkt_valid = 0; fifo_full = 0;
        step();
        fifo_full = 1;
        step();
        checks++;
        if (outs !== S_CHECK) begin
            errors++; $display("[TB] FAIL chk_check: got %b expected %b", outs, S_CHECK);
        end
        step();
        checks++;
        if (outs !== S_FULL) begin
            errors++; $display("[TB] FAIL chk_full: got %b expected %b", outs, S_FULL);
        end
        fifo_full = 0; parity_done = 1;
        step(); step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL chk_done: got %b expected %b", outs, S_DECODE);
        end
        parity_done = 0;
    endtask

    task automatic test_soft_reset();
        pkt_valid = 1; data_in = 8'h04;
        step(); step();
        fifo_full = 1; pkt_valid = 0;
        step();
        checks++;
        if (outs !== S_FULL) begin
            errors++; $display("[TB] FAIL soft_full_wins: got %b expected %b", outs, S_FULL);
        end
        soft_reset_2 = 1;
        step();
        checks++;
        if (outs !== S_FULL) begin
            errors++; $display("[TB] FAIL soft_other_port: got %b expected %b", outs, S_FULL);
        end
        soft_reset_2 = 0; soft_reset_0 = 1;
        step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL soft_own_port: got %b expected %b", outs, S_DECODE);
        end
        soft_reset_0 = 0; fifo_full = 0;
        step();
    endtask

    task automatic test_reset_mid_packet();
        pkt_valid = 1; data_in = 8'h01;
        step(); step();
        checks++;
        if (outs !== S_LD) begin
            errors++; $display("[TB] FAIL areset_ld: got %b expected %b", outs, S_LD);
        end
        #2 resetn = 0;
        #1;
        checks++;
        if (outs !== S_DECODE || addr_q !== 2'd0) begin
            errors++; $display("[TB] FAIL areset_async: got %b/%0d expected %b/0", outs, addr_q, S_DECODE);
        end
        clear_inputs();
        step();
        resetn = 1;
        step(); step();
        checks++;
        if (outs !== S_DECODE) begin
            errors++; $display("[TB] FAIL areset_idle: got %b expected %b", outs, S_DECODE);
        end
    endtask

    initial begin
        test_reset();
        test_normal_packet();
        test_invalid_addr();
        test_busy_dest_full_stall();
        test_parity_done_priority();
        test_check_full();
        test_soft_reset();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
